// File: rtl/uart_pkg.sv
// Shared UART register map plus the writer's FSM and operation encodings.
package uart_pkg;

    localparam logic [1:0] ADDR_TX  = 2'd0;
    localparam logic [1:0] ADDR_RX  = 2'd1;
    localparam logic [1:0] ADDR_DIV = 2'd2;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_STB,
        ST_REL,
        ST_GAP
    } state_t;

    // What the bus write in flight is for: decides retry and post-release behaviour.
    typedef enum logic [1:0] {
        OP_INIT,
        OP_CFG,
        OP_TX
    } op_t;

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO with power-of-two depth; a push and a pop on the same edge are both
// honoured even when full or empty (empty reads bypass the incoming byte).
module byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] pop_data,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full     = (count == FULL_COUNT);
    assign empty    = (count == '0);
    assign do_push  = push && (!full || pop);
    assign do_pop   = pop && (!empty || push);
    assign pop_data = empty ? push_data : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (!do_push && do_pop) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_wb_writer.sv
// Feeds buffered bytes and divider updates to a UART over a strobe/ack bus,
// pacing TX writes so each byte has a full frame time on the line.
module uart_wb_writer
    import uart_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int FREQ_DIV    = 78,
    parameter int GAP         = 12640,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] cfg_div,
    input  logic       cfg_we,
    output logic [1:0] wb_addr,
    output logic [7:0] wb_data,
    output logic       wb_we,
    output logic       wb_stb,
    output logic       wb_clk,
    input  logic       wb_ack,
    output logic       busy,
    output logic       err,
    output state_t     dbg_state
);

    // Handshakes: a byte moves on an edge where in_valid && in_ready, and in_data
    // must hold while in_valid waits. On the bus, stb/clk stay high with stable
    // addr/data until ack is sampled high, then both drop until ack is sampled low.

    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam int GW = $clog2(GAP + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);

    state_t        state, state_n;
    op_t           op, op_n;
    logic [1:0]    addr_n;
    logic [7:0]    data_n;
    logic          take_cfg, fifo_pop, tmo_hit;
    logic          fifo_full, fifo_empty;
    logic [7:0]    fifo_data;
    logic          cfg_pending;
    logic [7:0]    cfg_data;
    logic [TW-1:0] tmo_cnt;
    logic [GW-1:0] gap_cnt;

    byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (in_valid && in_ready),
        .push_data (in_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign in_ready  = !fifo_full && (state != ST_INIT);
    assign wb_stb    = (state == ST_STB);
    assign wb_clk    = (state == ST_STB);
    assign wb_we     = 1'b0;
    assign busy      = (state != ST_IDLE) || !fifo_empty;
    assign dbg_state = state;

    always_comb begin
        state_n  = state;
        op_n     = op;
        addr_n   = wb_addr;
        data_n   = wb_data;
        take_cfg = 1'b0;
        fifo_pop = 1'b0;
        tmo_hit  = 1'b0;
        case (state)
            ST_INIT: begin
                op_n    = OP_INIT;
                addr_n  = ADDR_DIV;
                data_n  = 8'(FREQ_DIV);
                state_n = ST_STB;
            end
            ST_IDLE: begin
                if (cfg_pending) begin
                    take_cfg = 1'b1;
                    op_n     = OP_CFG;
                    addr_n   = ADDR_DIV;
                    data_n   = cfg_data;
                    state_n  = ST_STB;
                end else if (!fifo_empty) begin
                    op_n    = OP_TX;
                    addr_n  = ADDR_TX;
                    data_n  = fifo_data;
                    state_n = ST_STB;
                end
            end
            ST_STB: begin
                if (wb_ack) begin
                    fifo_pop = (op == OP_TX);
                    state_n  = ST_REL;
                end else if (tmo_cnt == TMO_LAST) begin
                    tmo_hit = 1'b1;
                    state_n = ST_IDLE;
                end
            end
            ST_REL: begin
                if (!wb_ack) begin
                    state_n = (op == OP_TX) ? ST_GAP : ST_IDLE;
                end else if (tmo_cnt == TMO_LAST) begin
                    tmo_hit = 1'b1;
                    state_n = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_INIT;
            op          <= OP_INIT;
            wb_addr     <= '0;
            wb_data     <= '0;
            err         <= 1'b0;
            cfg_pending <= 1'b0;
            cfg_data    <= '0;
            tmo_cnt     <= '0;
            gap_cnt     <= '0;
        end else begin
            state   <= state_n;
            op      <= op_n;
            wb_addr <= addr_n;
            wb_data <= data_n;
            if (tmo_hit) begin
                err <= 1'b1;
            end
            // A divider write that never got acked goes back to pending; a newer
            // cfg_we already left cfg_data holding the value that should win.
            if (cfg_we) begin
                cfg_pending <= 1'b1;
                cfg_data    <= cfg_div;
            end else if (take_cfg) begin
                cfg_pending <= 1'b0;
            end else if (tmo_hit && state == ST_STB && op == OP_CFG) begin
                cfg_pending <= 1'b1;
            end
            tmo_cnt <= (state_n == state && (state == ST_STB || state == ST_REL))
                       ? tmo_cnt + 1'b1 : '0;
            gap_cnt <= (state_n == ST_GAP && state == ST_GAP) ? gap_cnt + 1'b1 : '0;
        end
    end

endmodule

// File: doc/uart_wb_writer.md
UART_WB_WRITER -- requirements
Module: uart_wb_writer

Interface
REQ-001 Parameter DEPTH, default 4, meaning byte-buffer entries (power of two, at least 2).
REQ-002 Parameter FREQ_DIV, default 78, meaning divider value written to the UART at reset exit.
REQ-003 Parameter GAP, default 12640, meaning minimum clk cycles from one TX write ack to the next strobe (one 8N1 frame at FREQ_DIV).
REQ-004 Parameter ACK_TIMEOUT, default 255, meaning clk cycles allowed for each ack edge.
REQ-005 clk  input  1  system clock; all logic on posedge clk.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 in_data  input  8  byte to transmit.
REQ-008 in_valid  input  1  in_data valid.
REQ-009 in_ready  output  1  buffer can accept; a byte transfers when in_valid and in_ready are both high at a clk edge.
REQ-010 cfg_div  input  8  new UART divider value.
REQ-011 cfg_we  input  1  one-cycle request to write cfg_div to the UART.
REQ-012 wb_addr  output  2  UART register address: 0 = TX, 2 = divider.
REQ-013 wb_data  output  8  write data to the UART.
REQ-014 wb_we  output  1  always low, because the UART decodes low as write.
REQ-015 wb_stb  output  1  bus cycle strobe.
REQ-016 wb_clk  output  1  bus phase qualifier.
REQ-017 wb_ack  input  1  UART acknowledge.
REQ-018 busy  output  1  high whenever the FSM is not in IDLE or the buffer is non-empty.
REQ-019 err  output  1  sticky ack-timeout flag.

Function
REQ-020 The block SHALL hold incoming bytes in a DEPTH-entry FIFO; in_ready = not full; the count wraps pointers modulo DEPTH; a push and pop in the same cycle while full or empty are both honoured, and the count is unchanged.
REQ-021 The FSM SHALL use states INIT, IDLE, STB, REL, GAP.
REQ-022 INIT: entered from reset; issues a divider write (addr 2, data FREQ_DIV); the next state after release is IDLE.
REQ-023 IDLE priority SHALL be: pending cfg request first, then a non-empty FIFO, otherwise stay in IDLE.
REQ-024 A cfg_we pulse SHALL be latched into a pending flag plus data register; a later pulse before service overwrites the data.
REQ-025 STB: the block SHALL drive wb_stb=1 and wb_clk=1 with stable addr and data, and wait for wb_ack=1; the cycle after ack is seen it SHALL move to REL.
REQ-026 REL: the block SHALL drive wb_clk=0 and wb_stb=0 and wait for wb_ack=0; the next state is GAP for a TX write, or IDLE for a divider write.
REQ-027 The FIFO SHALL be popped only on the cycle wb_ack is first seen high in STB for a TX write.
REQ-028 GAP: the block SHALL count GAP cycles (counter sized by $clog2(GAP+1)), then return to IDLE; a cfg request arriving during GAP waits for GAP to finish.
REQ-029 Each of STB and REL SHALL carry a cycle counter; reaching ACK_TIMEOUT sets err, drops wb_stb and wb_clk, and enters IDLE; in STB the byte is not popped and is retried.
REQ-030 Idle outputs SHALL be wb_stb=0, wb_clk=0, wb_we=0, and wb_addr/wb_data holding their last values.
REQ-031 Minimum latency from push into an empty FIFO to wb_stb high SHALL be 2 cycles.

Reset
REQ-032 Reset SHALL set: FIFO empty, in_ready=0 while in INIT then 1, wb_stb=0, wb_clk=0, wb_we=0, wb_addr=0, wb_data=0, err=0, cfg pending=0, all counters 0, state=INIT.
REQ-033 Reset asserted mid-transaction SHALL abandon it immediately: the buffered bytes are lost and the divider write is reissued.

Structure
REQ-034 UART register addresses (TX=0, RX=1, DIV=2) and FSM state encodings SHALL live in a shared uart_pkg.
REQ-035 The byte FIFO SHALL be a separate sub-module, byte_fifo, with DEPTH as its parameter.

Verification
REQ-036 Reset release with a UART model acking in 1 cycle -> first transaction is addr=2, data=78, we=0, before any TX write.
REQ-037 Push 0x55, 0xA3 back-to-back -> two addr=0 writes in order; the second wb_stb rises no sooner than GAP cycles after the first release completes.
REQ-038 Push 5 bytes with DEPTH=4 and no acks -> in_ready low after 4 accepted; 5th held until the first pop.
REQ-039 cfg_we with 0x0C while a TX write is in GAP -> divider write (addr 2, 0x0C) occurs before the next queued TX byte.
REQ-040 The model never acks -> err=1 after ACK_TIMEOUT cycles, byte retained, and a retry occurs once the model acks.
REQ-041 Reset asserted during STB -> wb_stb=0 and wb_clk=0 the next cycle, FIFO empty, INIT divider write repeated.
